// File: rtl/mem_3_client_arbiter_pkg.sv
// Shared types and helpers for the three-client memory arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_3_client_arbiter_pkg;

  localparam int NUM_CLIENTS = 3;

  typedef enum logic [1:0] {
    CLIENT_0 = 2'd0,
    CLIENT_1 = 2'd1,
    CLIENT_2 = 2'd2
  } client_id_t;

  // Outstanding read return: which client the next mem_dout belongs to.
  typedef struct packed {
    logic       vld;
    client_id_t id;
  } ret_t;

  // Fixed priority, client 0 highest.
  function automatic logic [NUM_CLIENTS-1:0] fp_pick(input logic [NUM_CLIENTS-1:0] req);
    logic [NUM_CLIENTS-1:0] g;
    g = '0;
    if (req[0])      g[0] = 1'b1;
    else if (req[1]) g[1] = 1'b1;
    else if (req[2]) g[2] = 1'b1;
    return g;
  endfunction

  // Round robin: first requester strictly after the last granted client.
  function automatic logic [NUM_CLIENTS-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                     input client_id_t last);
    logic [NUM_CLIENTS-1:0] g;
    logic                   found;
    int                     j;
    logic [1:0]             jj;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      j  = (int'(last) + i) % NUM_CLIENTS;
      jj = 2'(j);
      if (!found && req[jj]) begin
        g[jj] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // One-hot grant to client id; an all-zero vector maps to client 0.
  function automatic client_id_t onehot_to_id(input logic [NUM_CLIENTS-1:0] g);
    client_id_t id;
    id = CLIENT_0;
    if (g[1]) id = CLIENT_1;
    if (g[2]) id = CLIENT_2;
    return id;
  endfunction

endpackage

// File: rtl/single_port_mem.sv
// Single-port synchronous RAM, read-before-write on the same address.
// Latency: write commits at the clock edge; read data on q one cycle after the address.
// Backpressure: none, accepts one access every cycle.
module single_port_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 21,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    address,
  input  logic             wr_en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array and registered read port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[address] <= data;
    q <= mem[address];
  end

endmodule

// File: rtl/mem_3_client_arbiter.sv
// Arbitrates three clients onto one shared single-port memory, each client in its own address window.
// Latency: grant is combinational in the request cycle; read data returns one cycle after grant.
// Backpressure: a client holds its request until granted; one grant per cycle, fixed priority 0>1>2 or round robin with ARB_ROUND_ROBIN_EN.
module mem_3_client_arbiter
  import mem_3_client_arbiter_pkg::*;
#(
  parameter int WIDTH            = 64,
  parameter int SINGLE_MEM_DEPTH = 7,
  parameter int FULL_MEM_DEPTH   = 21,
  parameter int MEM_0_START_ADDR = 0,
  parameter int MEM_1_START_ADDR = 7,
  parameter int MEM_2_START_ADDR = 14
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                mem_0_req,
  input  logic                                mem_0_we,
  input  logic [$clog2(SINGLE_MEM_DEPTH)-1:0] mem_0_addr,
  input  logic [WIDTH-1:0]                    mem_0_din,
  output logic                                mem_0_gnt,
  output logic                                mem_0_rd_valid,
  input  logic                                mem_1_req,
  input  logic                                mem_1_we,
  input  logic [$clog2(SINGLE_MEM_DEPTH)-1:0] mem_1_addr,
  input  logic [WIDTH-1:0]                    mem_1_din,
  output logic                                mem_1_gnt,
  output logic                                mem_1_rd_valid,
  input  logic                                mem_2_req,
  input  logic                                mem_2_we,
  input  logic [$clog2(SINGLE_MEM_DEPTH)-1:0] mem_2_addr,
  input  logic [WIDTH-1:0]                    mem_2_din,
  output logic                                mem_2_gnt,
  output logic                                mem_2_rd_valid,
  output logic [WIDTH-1:0]                    mem_dout,
  output logic                                busy
);

  localparam int PAW = $clog2(FULL_MEM_DEPTH);

  logic [NUM_CLIENTS-1:0] req_vec;
  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [NUM_CLIENTS-1:0] gnt_vec;
  client_id_t             sel_id;
  logic                   sel_we;
  logic [PAW-1:0]         mem_addr;
  logic [WIDTH-1:0]       mem_din;
  logic                   mem_wr_en;
  logic [WIDTH-1:0]       mem_q;
  ret_t                   ret_q;

  assign req_vec = {mem_2_req, mem_1_req, mem_0_req};

`ifdef ARB_ROUND_ROBIN_EN
  client_id_t last_gnt;

  assign arb_gnt = rr_pick(req_vec, last_gnt);

  // Last-grant pointer; reset to client 2 so client 0 leads after reset.
  always_ff @(posedge clk) begin
    if (!rst_n)        last_gnt <= CLIENT_2;
    else if (|gnt_vec) last_gnt <= sel_id;
  end
`else
  assign arb_gnt = fp_pick(req_vec);
`endif

  // Grants are held off while reset is asserted so nothing touches the memory.
  assign gnt_vec   = rst_n ? arb_gnt : '0;
  assign mem_0_gnt = gnt_vec[0];
  assign mem_1_gnt = gnt_vec[1];
  assign mem_2_gnt = gnt_vec[2];

  // Steer the granted client's access onto the memory, translating into its window.
  always_comb begin
    sel_id   = onehot_to_id(gnt_vec);
    sel_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt_vec[0]) begin
      sel_we   = mem_0_we;
      mem_addr = PAW'(mem_0_addr) + PAW'(MEM_0_START_ADDR);
      mem_din  = mem_0_din;
    end else if (gnt_vec[1]) begin
      sel_we   = mem_1_we;
      mem_addr = PAW'(mem_1_addr) + PAW'(MEM_1_START_ADDR);
      mem_din  = mem_1_din;
    end else if (gnt_vec[2]) begin
      sel_we   = mem_2_we;
      mem_addr = PAW'(mem_2_addr) + PAW'(MEM_2_START_ADDR);
      mem_din  = mem_2_din;
    end
  end

  assign mem_wr_en = (|gnt_vec) & sel_we;

  single_port_mem #(
    .WIDTH (WIDTH),
    .DEPTH (FULL_MEM_DEPTH),
    .AW    (PAW)
  ) u_mem (
    .clock   (clk),
    .data    (mem_din),
    .address (mem_addr),
    .wr_en   (mem_wr_en),
    .q       (mem_q)
  );

  // Return register: remembers which client's read lands on mem_dout next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ret_q <= '0;
    end else begin
      ret_q.vld <= (|gnt_vec) & ~sel_we;
      ret_q.id  <= sel_id;
    end
  end

  // Suppressed during reset so a read cut off by reset never reports valid.
  assign mem_0_rd_valid = rst_n & ret_q.vld & (ret_q.id == CLIENT_0);
  assign mem_1_rd_valid = rst_n & ret_q.vld & (ret_q.id == CLIENT_1);
  assign mem_2_rd_valid = rst_n & ret_q.vld & (ret_q.id == CLIENT_2);

  assign mem_dout = mem_q;
  assign busy     = (|gnt_vec) | ret_q.vld;

endmodule

// File: tb/tb_mem_3_client_arbiter.sv
module tb_mem_3_client_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req, we;
  logic [2:0]  addr [3];
  logic [63:0] din  [3];
  logic [2:0]  gnt, rdv;
  logic [63:0] dout;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  mem_3_client_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_0_req      (req[0]),
    .mem_0_we       (we[0]),
    .mem_0_addr     (addr[0]),
    .mem_0_din      (din[0]),
    .mem_0_gnt      (gnt[0]),
    .mem_0_rd_valid (rdv[0]),
    .mem_1_req      (req[1]),
    .mem_1_we       (we[1]),
    .mem_1_addr     (addr[1]),
    .mem_1_din      (din[1]),
    .mem_1_gnt      (gnt[1]),
    .mem_1_rd_valid (rdv[1]),
    .mem_2_req      (req[2]),
    .mem_2_we       (we[2]),
    .mem_2_addr     (addr[2]),
    .mem_2_din      (din[2]),
    .mem_2_gnt      (gnt[2]),
    .mem_2_rd_valid (rdv[2]),
    .mem_dout       (dout),
    .busy           (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
    for (int k = 0; k < 3; k++) begin
      addr[k] = '0;
      din[k]  = '0;
    end
  endtask

  task automatic put(input int k, input logic w, input logic [2:0] a, input logic [63:0] d);
    req[k]  = 1'b1;
    we[k]   = w;
    addr[k] = a;
    din[k]  = d;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    req   = 3'b111;
    step();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b want 000", gnt); end
    checks++; if (rdv !== 3'b000) begin errors++; $display("FAIL rst_rdv: got %b want 000", rdv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rst_first_gnt: got %b want 001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_first_busy: got %b want 1", busy); end
    step();
    idle();
    #1;
    checks++; if (rdv !== 3'b001) begin errors++; $display("FAIL rst_first_rdv: got %b want 001", rdv); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_idle();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (gnt !== 3'b000 || dut.mem_wr_en !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL idle_%0d: gnt=%b we=%b busy=%b want 000/0/0", i, gnt, dut.mem_wr_en, busy); end
    end
  endtask

  task automatic test_write_read();
    step(); idle(); put(1, 1'b1, 3'd3, 64'hA5); #1;
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wr_gnt: got %b want 010", gnt); end
    checks++; if (dut.mem_addr !== 5'd10 || dut.mem_wr_en !== 1'b1)
      begin errors++; $display("FAIL wr_phys: addr=%0d we=%b want 10/1", dut.mem_addr, dut.mem_wr_en); end
    step(); idle(); put(1, 1'b0, 3'd3, 64'h0); #1;
    checks++; if (gnt !== 3'b010 || rdv !== 3'b000)
      begin errors++; $display("FAIL rd_gnt: gnt=%b rdv=%b want 010/000", gnt, rdv); end
    checks++; if (dut.mem_addr !== 5'd10 || dut.mem_wr_en !== 1'b0)
      begin errors++; $display("FAIL rd_phys: addr=%0d we=%b want 10/0", dut.mem_addr, dut.mem_wr_en); end
    step(); idle(); #1;
    checks++; if (rdv !== 3'b010 || dout !== 64'hA5 || busy !== 1'b1)
      begin errors++; $display("FAIL rd_ret: rdv=%b dout=%0h busy=%b want 010/a5/1", rdv, dout, busy); end
    step();
    checks++; if (rdv !== 3'b000 || busy !== 1'b0)
      begin errors++; $display("FAIL rd_done: rdv=%b busy=%b want 000/0", rdv, busy); end
  endtask

  task automatic test_raw();
    step(); idle(); put(0, 1'b1, 3'd2, 64'h55AA); #1;
    step(); idle(); put(0, 1'b0, 3'd2, 64'h0); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL raw_gnt: got %b want 001", gnt); end
    step(); idle(); #1;
    checks++; if (rdv !== 3'b001 || dout !== 64'h55AA)
      begin errors++; $display("FAIL raw_data: rdv=%b dout=%0h want 001/55aa", rdv, dout); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(); idle(); put(2, 1'b1, 3'(i), 64'h200 + 64'(i)); #1;
      checks++; if (gnt !== 3'b100 || dut.mem_addr !== 5'(14 + i))
        begin errors++; $display("FAIL b2b_wr_%0d: gnt=%b addr=%0d want 100/%0d", i, gnt, dut.mem_addr, 14 + i); end
    end
    for (int i = 0; i < 3; i++) begin
      step(); idle(); put(2, 1'b0, 3'(i), 64'h0); #1;
      checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL b2b_rd_gnt_%0d: got %b want 100", i, gnt); end
      if (i > 0) begin
        checks++; if (rdv !== 3'b100 || dout !== 64'h200 + 64'(i - 1))
          begin errors++; $display("FAIL b2b_rd_%0d: rdv=%b dout=%0h want 100/%0h", i, rdv, dout, 64'h200 + 64'(i - 1)); end
      end
    end
    step(); idle(); #1;
    checks++; if (rdv !== 3'b100 || dout !== 64'h202)
      begin errors++; $display("FAIL b2b_last: rdv=%b dout=%0h want 100/202", rdv, dout); end
  endtask

  task automatic test_window();
    step(); idle(); put(0, 1'b1, 3'd6, 64'hC0DE); #1;
    checks++; if (dut.mem_addr !== 5'd6) begin errors++; $display("FAIL win_c0: addr=%0d want 6", dut.mem_addr); end
    step(); idle(); put(2, 1'b1, 3'd6, 64'h1234); #1;
    checks++; if (gnt !== 3'b100 || dut.mem_addr !== 5'd20)
      begin errors++; $display("FAIL win_c2: gnt=%b addr=%0d want 100/20", gnt, dut.mem_addr); end
    step(); idle(); put(0, 1'b0, 3'd6, 64'h0); #1;
    step(); idle(); #1;
    checks++; if (rdv !== 3'b001 || dout !== 64'hC0DE)
      begin errors++; $display("FAIL win_rd: rdv=%b dout=%0h want 001/c0de", rdv, dout); end
  endtask

  task automatic test_unchecked();
    step(); idle(); put(0, 1'b1, 3'd7, 64'h77); #1;
    checks++; if (gnt !== 3'b001 || dut.mem_addr !== 5'd7)
      begin errors++; $display("FAIL oob_wr: gnt=%b addr=%0d want 001/7", gnt, dut.mem_addr); end
    step(); idle(); put(1, 1'b0, 3'd0, 64'h0); #1;
    step(); idle(); #1;
    checks++; if (rdv !== 3'b010 || dout !== 64'h77)
      begin errors++; $display("FAIL oob_alias: rdv=%b dout=%0h want 010/77", rdv, dout); end
  endtask

  task automatic test_fixed_priority();
    step(); idle(); put(0, 1'b0, 3'd1, 64'h0); put(2, 1'b0, 3'd1, 64'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL fp_gnt_%0d: got %b want 001", i, gnt); end
      if (i > 0) begin
        checks++; if (rdv !== 3'b001) begin errors++; $display("FAIL fp_rdv_%0d: got %b want 001", i, rdv); end
      end
    end
    step(); req[0] = 1'b0; #1;
    checks++; if (gnt !== 3'b100 || rdv !== 3'b001)
      begin errors++; $display("FAIL fp_drop: gnt=%b rdv=%b want 100/001", gnt, rdv); end
    step(); idle(); #1;
    checks++; if (rdv !== 3'b100) begin errors++; $display("FAIL fp_c2_rdv: got %b want 100", rdv); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g, prev_g;
    step(); idle(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) put(k, 1'b0, 3'd1, 64'h0);
    prev_g = 3'b000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      #1;
      exp_g = 3'b001 << (i % 3);
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt_%0d: got %b want %b", i, gnt, exp_g); end
      checks++; if (rdv !== prev_g) begin errors++; $display("FAIL rr_rdv_%0d: got %b want %b", i, rdv, prev_g); end
      prev_g = exp_g;
    end
    step(); idle(); #1;
    checks++; if (rdv !== 3'b100) begin errors++; $display("FAIL rr_last_rdv: got %b want 100", rdv); end
  endtask

  task automatic test_reset_mid();
    step(); idle(); put(0, 1'b0, 3'd6, 64'h0); #1;
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rm_gnt: got %b want 001", gnt); end
    step(); idle(); rst_n = 1'b0; #1;
    checks++; if (rdv !== 3'b000) begin errors++; $display("FAIL rm_rdv: got %b want 000", rdv); end
    step();
    checks++; if (rdv !== 3'b000 || busy !== 1'b0)
      begin errors++; $display("FAIL rm_after: rdv=%b busy=%b want 000/0", rdv, busy); end
    rst_n = 1'b1;
    put(1, 1'b0, 3'd3, 64'h0); #1;
    checks++; if (gnt !== 3'b010 || dut.mem_addr !== 5'd10)
      begin errors++; $display("FAIL rm_keep_gnt: gnt=%b addr=%0d want 010/10", gnt, dut.mem_addr); end
    step(); idle(); #1;
    checks++; if (rdv !== 3'b010 || dout !== 64'hA5)
      begin errors++; $display("FAIL rm_keep_data: rdv=%b dout=%0h want 010/a5", rdv, dout); end
  endtask

  initial begin
    idle();
    test_reset();
    test_idle();
    test_write_read();
    test_raw();
    test_back_to_back();
    test_window();
    test_unchecked();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_3_client_arbiter.md
MEM_3_CLIENT_ARBITER -- requirements
Module: mem_3_client_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, memory word width in bits.
REQ-002 SHALL have parameter SINGLE_MEM_DEPTH, default 7, words per client window.
REQ-003 SHALL have parameter FULL_MEM_DEPTH, default 21, total words in the shared memory.
REQ-004 SHALL have parameters MEM_0_START_ADDR, MEM_1_START_ADDR and MEM_2_START_ADDR, defaults 0, 7 and 14, window base addresses.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset, synchronous and active-low.
REQ-007 SHALL have, per client k in 0..2, port mem_k_req, input, 1 bit, access request.
REQ-008 SHALL have, per client k, port mem_k_we, input, 1 bit, 1 = write, 0 = read.
REQ-009 SHALL have, per client k, port mem_k_addr, input, clog2(SINGLE_MEM_DEPTH) bits, window-relative address.
REQ-010 SHALL have, per client k, port mem_k_din, input, WIDTH bits, write data.
REQ-011 SHALL have, per client k, port mem_k_gnt, output, 1 bit, one-cycle grant pulse.
REQ-012 SHALL have, per client k, port mem_k_rd_valid, output, 1 bit, read data valid for client k.
REQ-013 SHALL have port mem_dout, output, WIDTH bits, shared read data bus.
REQ-014 SHALL have port busy, output, 1 bit, high while a grant or read return is in flight.

Function
REQ-015 Client SHALL hold req/we/addr/din stable until its gnt; request is consumed in the gnt cycle.
REQ-016 At most one gnt SHALL be high per cycle; gnt is combinational from current req and arbitration state.
REQ-017 Granted access SHALL drive the shared memory in the same cycle at physical address {zero-extended addr} + MEM_k_START_ADDR, width clog2(FULL_MEM_DEPTH).
REQ-018 Granted write SHALL commit din at the clock edge ending the gnt cycle; no rd_valid follows.
REQ-019 Granted read SHALL return data on mem_dout with mem_k_rd_valid high exactly one cycle after gnt (latency 1); mem_dout is don't-care otherwise.
REQ-020 A one-entry return register {valid, client id[1:0]} SHALL track the outstanding read; back-to-back reads SHALL sustain one grant per cycle.
REQ-021 Read after write to the same address in consecutive grants SHALL return the newly written data.
REQ-022 No request active: memory write enable 0, no gnt, arbitration state unchanged.
REQ-023 Address >= SINGLE_MEM_DEPTH SHALL still be granted and translated unchecked; behaviour beyond FULL_MEM_DEPTH is undefined.
REQ-024 busy SHALL equal (any gnt) OR (return register valid).

Reset
REQ-025 While rst_n = 0 at a clock edge: all gnt 0, all rd_valid 0, return register cleared, last-grant pointer = 2.
REQ-026 Reset mid-operation SHALL drop any pending read return without asserting rd_valid; memory contents are not cleared.
REQ-027 Cycle after rst_n rises: client 0 SHALL win if requesting.

Configuration
REQ-028 With ARB_ROUND_ROBIN_EN defined, grant SHALL go to the first requester after the last-grant pointer (order 0,1,2 cyclic); pointer updates on each grant.
REQ-029 Without ARB_ROUND_ROBIN_EN, grant SHALL be fixed priority 0 > 1 > 2 and the pointer SHALL be absent.

Structure
REQ-030 Client-id type (2 bits) and client count constant 3 SHALL live in a shared package; window base defaults remain module parameters.
REQ-031 The storage SHALL be one instance of the existing single_port_mem sub-module (clock, data, address, wr_en, q); no other sub-module.

Verification
REQ-032 Reset; client 1 writes 0xA5 to addr 3; client 1 reads addr 3 -> physical address 10 written; read gnt cycle N, mem_1_rd_valid at N+1, mem_dout = 0xA5.
REQ-033 ARB_ROUND_ROBIN_EN, all three hold read requests for 6 cycles -> gnt order 0,1,2,0,1,2; rd_valid follows each by one cycle with the matching client id.
REQ-034 Without macro, clients 0 and 2 request continuously -> client 0 granted every cycle; client 2 is never granted until req_0 drops.
REQ-035 Client 2 writes 0x1234 to addr 6 then client 0 reads addr 6 -> addresses 20 and 6 used; client 0 receives its own prior data, not 0x1234.
REQ-036 Read granted in cycle N; rst_n = 0 at edge N+1 -> no rd_valid in N+1; busy = 0 after reset.
